// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, ALU codes,
// opcodes, datapath mux selects and the branch-condition helper.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JALR,
        S_JAL
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SRA  = 4'b1000,
        ALU_SLL  = 4'b1001
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_MEMDATA   = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    // Branch condition from funct3 and the flags of the rs1 - rs2 subtraction.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero, input logic negative,
                                          input logic carry, input logic overflow);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return negative ^ overflow;
            3'b101:  return !(negative ^ overflow);
            3'b110:  return !carry;
            3'b111:  return carry;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_if.sv
// Instruction/flag inputs and datapath control outputs of the multicycle controller.
// master = controller side, slave = datapath side.
interface mc_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       Negative;
    logic       Carry;
    logic       Overflow;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic [2:0] ImmSrc;
    logic       illegal_instr;

    modport master (
        input  op, funct3, funct7b5, Zero, Negative, Carry, Overflow,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_instr
    );

    modport slave (
        output op, funct3, funct7b5, Zero, Negative, Carry, Overflow,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal_instr
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational funct3/funct7 decode to ALU operation for R-type and I-type ALU ops.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_op_t    alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            // Instr[30] only means SUB for register-register ops; for addi it is immediate data.
            3'b000: alu_control = (op == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_control = ALU_SLL;
            3'b010: alu_control = ALU_SLT;
            3'b011: alu_control = ALU_SLTU;
            3'b100: alu_control = ALU_XOR;
            3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_control = ALU_OR;
            3'b111: alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore FSM controller for a multicycle RV32I datapath; write enables are
// gated off during reset so an abandoned instruction commits nothing.
module mc_controller
    import mc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    mc_if.master bus
);

    state_t      state;
    state_t      state_next;
    alu_op_t     dec_alu;

    logic        pc_write;
    logic        adr_src;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    logic        illegal;
    result_src_t result_src;
    alu_src_a_t  alu_src_a;
    alu_src_b_t  alu_src_b;
    alu_op_t     alu_control;
    imm_src_t    imm_src;

    alu_decoder u_alu_decoder (
        .op          (bus.op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .alu_control (dec_alu)
    );

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next  = state;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        illegal     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_ADD;

        case (state)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch/JAL target is computed here while the instruction is decoded.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE:         state_next = S_MEMADR;
                    OP_RTYPE:                  state_next = S_EXECR;
                    OP_ITYPE, OP_LUI, OP_AUIPC: state_next = S_EXECI;
                    OP_BRANCH:                 state_next = S_BRANCH;
                    OP_JAL:                    state_next = S_JAL;
                    OP_JALR:                   state_next = S_JALR;
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = SRCA_RS1;
                alu_control = dec_alu;
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b  = SRCB_IMM;
                state_next = S_ALUWB;
                case (bus.op)
                    OP_LUI:   alu_src_a = SRCA_ZERO;
                    OP_AUIPC: alu_src_a = SRCA_OLDPC;
                    default: begin
                        alu_src_a   = SRCA_RS1;
                        alu_control = dec_alu;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = SRCA_RS1;
                alu_control = ALU_SUB;
                pc_write    = branch_taken(bus.funct3, bus.Zero, bus.Negative,
                                           bus.Carry, bus.Overflow);
                state_next  = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = S_JAL;
            end
            S_JAL: begin
                // Jump to ALUOut while computing the link value OldPC+4 for ALUWB.
                pc_write   = 1'b1;
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        imm_src = IMM_I;
        case (bus.op)
            OP_STORE:         imm_src = IMM_S;
            OP_BRANCH:        imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

    assign bus.PCWrite       = pc_write  & ~reset;
    assign bus.IRWrite       = ir_write  & ~reset;
    assign bus.MemWrite      = mem_write & ~reset;
    assign bus.RegWrite      = reg_write & ~reset;
    assign bus.illegal_instr = illegal   & ~reset;
    assign bus.AdrSrc        = adr_src;
    assign bus.ResultSrc     = result_src;
    assign bus.ALUSrcA       = alu_src_a;
    assign bus.ALUSrcB       = alu_src_b;
    assign bus.ALUControl    = alu_control;
    assign bus.ImmSrc        = imm_src;

endmodule
